// File: rtl/serial_subtractor4.sv
// Bit-serial unsigned subtractor, LSB first: accept a/b, out_valid WIDTH edges after accept.
// One operation in flight; DONE holds diff until out_ready, and in_ready is 0 outside IDLE.
module serial_subtractor4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   diff
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t          state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             br;
  logic [CW-1:0]    cnt;

  logic a_bit;
  logic b_bit;
  logic d_bit;
  logic br_next;

  always_comb begin
    a_bit   = a_sh[0];
    b_bit   = b_sh[0];
    d_bit   = a_bit ^ b_bit ^ br;
    br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      a_sh      <= '0;
      b_sh      <= '0;
      br        <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            br       <= 1'b0;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          // Bit cnt of diff is rewritten in place; older bits keep the previous result until reached.
          diff[cnt] <= d_bit;
          br        <= br_next;
          a_sh      <= a_sh >> 1;
          b_sh      <= b_sh >> 1;
          cnt       <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            diff[WIDTH] <= br_next;
            out_valid   <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          // Returning to IDLE raises in_ready only next cycle, so no accept on the leaving edge.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor4.sv
// Self-checking bench for serial_subtractor4: directed, exhaustive and random operations
// against an arithmetic reference (a - b mod 2^(WIDTH+1)) with fixed-latency expectations.
module tb_serial_subtractor4;

  localparam int WIDTH = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   diff;

  int n_cmp;
  int n_err;

  serial_subtractor4 #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_diff(input int x, input int y);
    int m;
    m = 1 << (WIDTH + 1);
    return ((x - y) % m + m) % m;
  endfunction

  task automatic scramble;
    a        = WIDTH'($urandom);
    b        = WIDTH'($urandom);
    in_valid = 1'($urandom);
  endtask

  // Full operation from IDLE; bp = cycles of out_ready=0 while in DONE.
  task automatic run_op(input int ta, input int tb, input int bp);
    int exp;
    exp       = ref_diff(ta, tb);
    a         = WIDTH'(ta);
    b         = WIDTH'(tb);
    in_valid  = 1'b1;
    out_ready = (bp == 0);
    step;
    chk("accept_rdy", in_ready, 0);
    chk("accept_vld", out_valid, 0);
    for (int i = 1; i < WIDTH; i++) begin
      scramble;
      step;
      chk("calc_vld", out_valid, 0);
      chk("calc_rdy", in_ready, 0);
    end
    scramble;
    step;
    chk("done_vld", out_valid, 1);
    chk("done_rdy", in_ready, 0);
    chk("done_diff", diff, exp);
    for (int i = 0; i < bp; i++) begin
      scramble;
      out_ready = 1'b0;
      step;
      chk("bp_vld", out_valid, 1);
      chk("bp_rdy", in_ready, 0);
      chk("bp_diff", diff, exp);
    end
    // Offer an operand on the leaving edge; it must not be taken.
    a         = WIDTH'($urandom);
    b         = WIDTH'($urandom);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step;
    chk("ret_vld", out_valid, 0);
    chk("ret_rdy", in_ready, 1);
    chk("ret_diff", diff, exp);
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    a         = 4'd9;
    b         = 4'd3;
    out_ready = 1'b0;
    step;
    step;
    chk("rst_rdy", in_ready, 1);
    chk("rst_vld", out_valid, 0);
    chk("rst_diff", diff, 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    step;
    chk("idle_vld", out_valid, 0);
    chk("idle_diff", diff, 0);

    run_op(9, 3, 0);
    chk("basic_diff", diff, 5'b00110);
    run_op(3, 9, 0);
    chk("borrow_diff", diff, 5'b11010);
    run_op(0, 15, 0);
    chk("zero_max_diff", diff, 5'b10001);
    run_op(15, 0, 0);
    chk("max_zero_diff", diff, 5'b01111);
    run_op(7, 7, 0);
    chk("equal_diff", diff, 5'b00000);
    run_op(9, 3, 5);

    // Idle cycles keep the last result.
    for (int i = 0; i < 3; i++) begin
      step;
      chk("hold_idle_diff", diff, 6);
      chk("hold_idle_vld", out_valid, 0);
    end

    // Reset in the middle of CALC, with in_valid high on the reset edge.
    a        = 4'd9;
    b        = 4'd3;
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    step;
    rst      = 1'b1;
    in_valid = 1'b1;
    step;
    chk("midrst_rdy", in_ready, 1);
    chk("midrst_vld", out_valid, 0);
    chk("midrst_diff", diff, 0);
    rst      = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < WIDTH + 1; i++) begin
      step;
      chk("midrst_novld", out_valid, 0);
    end
    run_op(12, 5, 0);

    // Reset while holding a result in DONE.
    a        = 4'd2;
    b        = 4'd11;
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    for (int i = 0; i < WIDTH; i++) step;
    chk("pre_rst_vld", out_valid, 1);
    rst = 1'b1;
    step;
    chk("donerst_vld", out_valid, 0);
    chk("donerst_rdy", in_ready, 1);
    chk("donerst_diff", diff, 0);
    rst = 1'b0;

    for (int x = 0; x < (1 << WIDTH); x++) begin
      for (int y = 0; y < (1 << WIDTH); y++) begin
        run_op(x, y, 0);
      end
    end

    for (int i = 0; i < 40; i++) begin
      run_op(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), int'($urandom_range(3, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_subtractor4.md
SERIAL_SUBTRACTOR4 -- requirements
Module: serial_subtractor4

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 4, operand width in bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  operand pair on a/b is valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 a  input  WIDTH  minuend, unsigned.
REQ-007 b  input  WIDTH  subtrahend, unsigned.
REQ-008 out_valid  output  1  diff holds a completed result.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 diff  output  WIDTH+1  result; diff = ({1'b0,a} - {1'b0,b}) mod 2^(WIDTH+1); diff[WIDTH] is the borrow, set when a < b.

Function
REQ-011 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-012 IDLE: in_ready=1, out_valid=0; an edge with in_valid=1 SHALL capture a and b into internal shift registers, clear the borrow register and bit counter, and go to CALC.
REQ-013 IDLE with in_valid=0 SHALL stay in IDLE with diff unchanged.
REQ-014 CALC: in_ready=0, out_valid=0; each edge SHALL compute one bit, LSB first: d_i = a_i ^ b_i ^ br, br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br).
REQ-015 Each CALC edge SHALL shift d_i into the result register at bit position i and increment the bit counter.
REQ-016 After exactly WIDTH CALC edges the FSM SHALL go to DONE, and diff[WIDTH] SHALL equal the final borrow.
REQ-017 Latency: if the accept is at edge E0, out_valid SHALL be 1 in the cycle after edge E(WIDTH); that is edge E4 for WIDTH=4.
REQ-018 DONE: out_valid=1 and in_ready=0; diff SHALL hold stable until the handshake completes.
REQ-019 DONE with out_ready=1 at an edge SHALL return to IDLE; out_valid SHALL drop in the next cycle.
REQ-020 DONE with out_ready=0 SHALL hold indefinitely (backpressure) with diff stable.
REQ-021 No new operand SHALL be accepted on the edge that leaves DONE; the minimum initiation interval is WIDTH+2 cycles.
REQ-022 a, b and in_valid SHALL be ignored outside IDLE; operand changes during CALC SHALL NOT affect the result.
REQ-023 diff SHALL keep its last value after the return to IDLE until the next CALC overwrites it.
REQ-024 in_ready SHALL depend only on state, with no combinational path from in_valid or out_ready.
REQ-025 The carry/borrow arithmetic SHALL wrap modulo 2^(WIDTH+1) with no saturation, including the cases a=b and a=0,b=2^WIDTH-1.

Reset
REQ-026 rst=1 at an edge SHALL force state IDLE, in_ready=1, out_valid=0, diff=0, internal shift registers=0, bit counter=0, borrow=0.
REQ-027 rst SHALL take priority over all other inputs in every state, including mid-CALC and DONE; no result SHALL be produced for an operation aborted by reset.
REQ-028 With rst=1 and in_valid=1 on the same edge, no operand SHALL be accepted.

Verification
REQ-029 Basic: a=9, b=3 accepted at E0 -> out_valid=1 after E4, diff=5'b00110.
REQ-030 Borrow: a=3, b=9 -> diff=5'b11010 (-6); a=0, b=15 -> diff=5'b10001; a=15, b=0 -> diff=5'b01111; a=7, b=7 -> diff=5'b00000.
REQ-031 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid stays 1, diff stable, in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-032 Busy input ignored: toggle a, b and in_valid every cycle during CALC -> result matches only the operands captured at E0.
REQ-033 Reset mid-CALC: rst at E2 -> next cycle in_ready=1, out_valid=0, diff=0; a new operation afterwards completes correctly.
REQ-034 Exhaustive: all 256 (a,b) pairs back-to-back with out_ready=1 -> every diff equals the reference a-b mod 32, with 6 cycles between accepts.
